// File: rtl/cacheline_burst_responder_pkg.sv
// Shared types and constants for the cache line <-> word memory burst responder.
// A cache line is WORDS_PER_LINE little-endian-packed 16-bit words.
package cacheline_burst_responder_pkg;

  localparam int WORD_W           = 16;
  localparam int WORDS_PER_LINE   = 8;
  localparam int LINE_W           = WORD_W * WORDS_PER_LINE;
  localparam int ADDR_W           = 16;
  localparam int LINE_OFFSET_BITS = 4;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] cache_flow;
  typedef logic [ADDR_W-1:0] lc3b_addr;
  typedef logic [2:0]        beat_idx_t;

  function automatic lc3b_addr line_base(input lc3b_addr addr);
    return {addr[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

  // Base has zero low bits, so the add never carries out of the line.
  function automatic lc3b_addr beat_addr(input lc3b_addr base, input beat_idx_t idx);
    return base + lc3b_addr'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/cacheline_burst_responder_if.sv
// Cache-side line bus plus memory-side word bus of the burst responder.
// The slave modport is the responder's view; master is the surrounding system.
interface cacheline_burst_responder_if;
  import cacheline_burst_responder_pkg::*;

  logic      pmem_read;
  logic      pmem_write;
  lc3b_addr  pmem_address;
  cache_flow pmem_wdata;
  cache_flow pmem_rdata;
  logic      pmem_resp;

  logic      mem_read;
  logic      mem_write;
  lc3b_addr  mem_address;
  lc3b_word  mem_wdata;
  lc3b_word  mem_rdata;
  logic      mem_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    output pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    input  pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/cacheline_burst_responder.sv
// Turns one cache line read/write into eight sequential word beats on the memory port
// and returns the assembled line with a one-cycle pmem_resp pulse.
module cacheline_burst_responder
  import cacheline_burst_responder_pkg::*;
(
  input logic                         clk,
  input logic                         rst_n,
  cacheline_burst_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, DONE} state_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(WORDS_PER_LINE - 1);

  state_t    state;
  lc3b_addr  base;
  cache_flow wline;
  cache_flow rline;
  beat_idx_t idx;
  beat_idx_t next_idx;
  logic      rd;
  logic      wr;
  logic      resp;
  lc3b_addr  maddr;
  lc3b_word  mwdata;

  assign next_idx = idx + 3'd1;

  // Write has priority so a dirty writeback precedes the fill that follows it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      base   <= '0;
      wline  <= '0;
      rline  <= '0;
      idx    <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      resp   <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp <= 1'b0;
          idx  <= '0;
          if (bus.pmem_write) begin
            state  <= WR_BEAT;
            base   <= line_base(bus.pmem_address);
            maddr  <= line_base(bus.pmem_address);
            wline  <= bus.pmem_wdata;
            mwdata <= bus.pmem_wdata[WORD_W-1:0];
            wr     <= 1'b1;
          end else if (bus.pmem_read) begin
            state <= RD_BEAT;
            base  <= line_base(bus.pmem_address);
            maddr <= line_base(bus.pmem_address);
            rd    <= 1'b1;
          end
        end
        RD_BEAT, WR_BEAT: begin
          if (bus.mem_resp) begin
            if (state == RD_BEAT) begin
              rline[idx*WORD_W +: WORD_W] <= bus.mem_rdata;
            end
            idx <= next_idx;
            if (idx == LAST_BEAT) begin
              rd    <= 1'b0;
              wr    <= 1'b0;
              resp  <= 1'b1;
              state <= DONE;
            end else begin
              maddr  <= beat_addr(base, next_idx);
              mwdata <= wline[next_idx*WORD_W +: WORD_W];
            end
          end
        end
        DONE: begin
          resp  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_rdata  = rline;
  assign bus.pmem_resp   = resp;
  assign bus.mem_read    = rd;
  assign bus.mem_write   = wr;
  assign bus.mem_address = maddr;
  assign bus.mem_wdata   = mwdata;

endmodule
